// File: rtl/mp_ram_pkg.sv
// mp_ram_pkg: default sizing, bypass mode encodings and the packed-bus slice helper
// shared by the RAM top and its write arbiter.
package mp_ram_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_NUM_RD  = 4;
    localparam int DEF_NUM_WR  = 2;

    // Widest packed bus / widest single field the slice helper handles.
    localparam int MAX_BUS_W   = 512;
    localparam int MAX_SLICE_W = 64;

    typedef enum logic [0:0] {
        BYPASS_OFF = 1'b0,
        BYPASS_ON  = 1'b1
    } bypass_mode_e;

    // Return field 'idx' of width 'width' from a zero-extended packed bus.
    // The caller narrows the result to the real field width.
    function automatic logic [MAX_SLICE_W-1:0] get_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        return MAX_SLICE_W'(bus >> (idx * width));
    endfunction

endpackage

// File: rtl/mp_ram_wr_arb.sv
// mp_ram_wr_arb: turns the packed write ports into a per-entry write strobe and
// data word. Out-of-range addresses are dropped, the highest enabled port wins
// when several target one entry, and such a collision raises 'conflict'.
module mp_ram_wr_arb
    import mp_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2**DEF_ADDR_W,
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DEPTH-1:0]         ent_hit,
    output logic [DATA_W-1:0]        ent_data [DEPTH],
    output logic                     conflict
);

    logic [MAX_BUS_W-1:0] addr_bus_s;
    logic [MAX_BUS_W-1:0] data_bus_s;
    logic [ADDR_W-1:0]    port_addr_s [NUM_WR];
    logic [DATA_W-1:0]    port_data_s [NUM_WR];
    logic [NUM_WR-1:0]    port_ok_s;

    assign addr_bus_s = MAX_BUS_W'(wr_addr);
    assign data_bus_s = MAX_BUS_W'(wr_data);

    // Unpack each write port and qualify it with its strobe and range check.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            port_addr_s[k] = ADDR_W'(get_slice(addr_bus_s, k, ADDR_W));
            port_data_s[k] = DATA_W'(get_slice(data_bus_s, k, DATA_W));
            port_ok_s[k]   = wr_en[k] & ({1'b0, port_addr_s[k]} < (ADDR_W+1)'(DEPTH));
        end
    end

    // Per-entry decode; scanning ports upward lets the highest index overwrite lower ones.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            ent_hit[e]  = 1'b0;
            ent_data[e] = {DATA_W{1'b0}};
            for (int k = 0; k < NUM_WR; k++) begin
                ent_hit[e]  = ent_hit[e] | (port_ok_s[k] & (port_addr_s[k] == ADDR_W'(e)));
                ent_data[e] = (port_ok_s[k] & (port_addr_s[k] == ADDR_W'(e))) ?
                              port_data_s[k] : ent_data[e];
            end
        end
    end

    // Any pair of qualified ports landing on the same entry is a conflict.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int k = i + 1; k < NUM_WR; k++) begin
                conflict = conflict | (port_ok_s[i] & port_ok_s[k] &
                                       (port_addr_s[i] == port_addr_s[k]));
            end
        end
    end

endmodule

// File: rtl/mp_ram.sv
// mp_ram: multi-port synchronous RAM with per-entry valid bitmap, registered
// reads carrying a valid flag, optional same-cycle write-to-read bypass and a
// bulk invalidate. Storage contents are never reset; isWritten is authoritative.
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int BYPASS = int'(BYPASS_ON)
) (
    input  logic                     Clk,
    input  logic                     reset_n,
    input  logic [NUM_WR-1:0]        writeEnable,
    input  logic [NUM_WR*ADDR_W-1:0] writeAddr,
    input  logic [NUM_WR*DATA_W-1:0] dataIn,
    input  logic [NUM_RD-1:0]        readEnable,
    input  logic [NUM_RD*ADDR_W-1:0] readAddr,
    input  logic                     clearValid,
    output logic [NUM_RD*DATA_W-1:0] dOut,
    output logic [NUM_RD-1:0]        rdValid,
    output logic [DEPTH-1:0]         isWritten,
    output logic                     wrConflict
);

    localparam int   IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic BYP_EN = (BYPASS == int'(BYPASS_ON));

    logic [DEPTH-1:0]     ent_hit_s;
    logic [DATA_W-1:0]    ent_data_s [DEPTH];
    logic                 conflict_s;

    logic [DATA_W-1:0]    mem_d [DEPTH];
    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0]     valid_d;
    logic [DEPTH-1:0]     valid_q;
    logic                 conflict_d;
    logic                 conflict_q;
    logic [MAX_BUS_W-1:0] raddr_bus_s;

    mp_ram_wr_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR)
    ) u_wr_arb (
        .wr_en    (writeEnable),
        .wr_addr  (writeAddr),
        .wr_data  (dataIn),
        .ent_hit  (ent_hit_s),
        .ent_data (ent_data_s),
        .conflict (conflict_s)
    );

    // Next storage contents: winning write data replaces the entry.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = ent_hit_s[e] ? ent_data_s[e] : mem_q[e];
        end
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    // Next valid bitmap: invalidate first, then same-cycle writes set their bits.
    always_comb begin
        valid_d    = (clearValid ? {DEPTH{1'b0}} : valid_q) | ent_hit_s;
        conflict_d = conflict_s;
    end

    // Valid bitmap and one-cycle conflict flag.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= {DEPTH{1'b0}};
            conflict_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
        end
    end

    assign isWritten   = valid_q;
    assign wrConflict  = conflict_q;
    assign raddr_bus_s = MAX_BUS_W'(readAddr);

    generate
        for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
            logic [ADDR_W-1:0] ra_s;
            logic [IDX_W-1:0]  idx_s;
            logic              in_rng_s;
            logic [DATA_W-1:0] dout_d;
            logic [DATA_W-1:0] dout_q;
            logic              vld_d;
            logic              vld_q;

            assign ra_s     = ADDR_W'(get_slice(raddr_bus_s, j, ADDR_W));
            assign idx_s    = IDX_W'(ra_s);
            assign in_rng_s = ({1'b0, ra_s} < (ADDR_W+1)'(DEPTH));

            // Read result: hold when idle, zero when out of range, else bypass or stored word.
            always_comb begin
                dout_d = dout_q;
                vld_d  = vld_q;
                if (!readEnable[j]) begin
                    dout_d = dout_q;
                    vld_d  = vld_q;
                end else if (!in_rng_s) begin
                    dout_d = {DATA_W{1'b0}};
                    vld_d  = 1'b0;
                end else if (BYP_EN && ent_hit_s[idx_s]) begin
                    dout_d = ent_data_s[idx_s];
                    vld_d  = 1'b1;
                end else begin
                    dout_d = mem_q[idx_s];
                    vld_d  = valid_q[idx_s];
                end
            end

            // Registered read data and valid flag for this port.
            always_ff @(posedge Clk or negedge reset_n) begin
                if (!reset_n) begin
                    dout_q <= {DATA_W{1'b0}};
                    vld_q  <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    vld_q  <= vld_d;
                end
            end

            assign dOut[j*DATA_W +: DATA_W] = dout_q;
            assign rdValid[j]               = vld_q;
        end
    endgenerate

endmodule
